// File: rtl/fetch_sequencer.sv
// fetch_sequencer: Y86 fetch-stage sequencer. Owns the predicted-PC register,
// selects f_pc (mispredict / ret redirect / prediction), classifies fetch
// status and drives F/D/E stall and bubble controls for ret, mispredict,
// load/use and halt.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating stall and flush
// performance counters (perf_stall_cnt, perf_flush_cnt).
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          IMEM_SIZE = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        imem_error,
  input  logic        lu_hazard,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [2:0]  W_stat,
  output logic [63:0] f_pc,
  output logic [2:0]  f_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        cpu_halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam logic [3:0]  I_HALT = 4'h0;
  localparam logic [3:0]  I_JXX  = 4'h7;
  localparam logic [3:0]  I_CALL = 4'h8;
  localparam logic [3:0]  I_RET  = 4'h9;
  localparam logic [3:0]  I_MAX  = 4'hB;
  localparam logic [2:0]  S_AOK  = 3'd1;
  localparam logic [2:0]  S_HLT  = 3'd2;
  localparam logic [2:0]  S_ADR  = 3'd3;
  localparam logic [2:0]  S_INS  = 3'd4;
  // Largest instruction is 10 bytes; the whole word must lie inside memory.
  localparam logic [64:0] IMEM_LIM = 65'(IMEM_SIZE);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    RET  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] pred_pc;
  logic        mispredict;
  logic        ret_wb;

  assign mispredict = (M_icode == I_JXX) && !M_Cnd;
  assign ret_wb     = (W_icode == I_RET);

  // PC select: mispredicted branch first, then returning ret, else prediction.
  always_comb begin
    if (mispredict)  f_pc = M_valA;
    else if (ret_wb) f_pc = W_valM;
    else             f_pc = pred_pc;
  end

  // Fetch status classification; address errors outrank opcode checks.
  always_comb begin
    if (imem_error || (({1'b0, f_pc} + 65'd9) >= IMEM_LIM)) f_stat = S_ADR;
    else if (f_icode > I_MAX)                                f_stat = S_INS;
    else if (f_icode == I_HALT)                              f_stat = S_HLT;
    else                                                     f_stat = S_AOK;
  end

  // Next-state and pipeline controls; halted CPU freezes everything,
  // then mispredict, then load/use, then the ret/halt sequencing.
  always_comb begin
    state_d  = state_q;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    if (cpu_halted) begin
      F_stall  = 1'b1;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
    end else if (mispredict) begin
      // Wrong-path ret/halt are squashed: always resume normal fetch.
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      state_d  = RUN;
    end else if (lu_hazard) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (f_icode == I_RET)    state_d = RET;
          else if (f_stat != S_AOK) state_d = HALT;
        end
        RET: begin
          if (ret_wb) begin
            // Return address is on f_pc now; treat this fetch like RUN.
            if (f_icode == I_RET)     state_d = RET;
            else if (f_stat != S_AOK) state_d = HALT;
            else                      state_d = RUN;
          end else begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
          end
        end
        HALT: begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Predicted PC: call/jXX predict taken, everything else falls through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc <= RESET_PC;
    end else if (!F_stall) begin
      if ((f_icode == I_JXX) || (f_icode == I_CALL)) pred_pc <= f_valC;
      else                                           pred_pc <= f_valP;
    end
  end

  // Sticky halt flag, raised by any non-AOK status retiring in write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cpu_halted <= 1'b0;
    else if (W_stat != S_AOK) cpu_halted <= 1'b1;
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating stall/flush counters, frozen once the CPU has halted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else if (!cpu_halted) begin
      if (F_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (mispredict && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer (default build, RESET_PC=0,
// IMEM_SIZE=2048) with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  f_icode;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic        imem_error;
  logic        lu_hazard;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [2:0]  W_stat;
  logic [63:0] f_pc;
  logic [2:0]  f_stat;
  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic        E_bubble;
  logic        cpu_halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.RESET_PC(64'h0), .IMEM_SIZE(2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .imem_error(imem_error), .lu_hazard(lu_hazard),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM), .W_stat(W_stat),
    .f_pc(f_pc), .f_stat(f_stat),
    .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble),
    .cpu_halted(cpu_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_icode    = 4'h1;
    f_valC     = 64'h0;
    f_valP     = 64'h0;
    imem_error = 1'b0;
    lu_hazard  = 1'b0;
    M_icode    = 4'h1;
    M_Cnd      = 1'b1;
    M_valA     = 64'h0;
    W_icode    = 4'h1;
    W_valM     = 64'h0;
    W_stat     = 3'd1;
  endtask

  task automatic chk_ctl(input string tag, input logic fs, input logic ds,
                         input logic db, input logic eb);
    chk_eq({tag, ".F_stall"},  F_stall,  fs);
    chk_eq({tag, ".D_stall"},  D_stall,  ds);
    chk_eq({tag, ".D_bubble"}, D_bubble, db);
    chk_eq({tag, ".E_bubble"}, E_bubble, eb);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    // Reset values
    chk_eq("rst.f_pc", f_pc, 64'h0);
    chk_eq("rst.f_stat", f_stat, 64'd1);
    chk_eq("rst.cpu_halted", cpu_halted, 64'd0);
    chk_ctl("rst", 0, 0, 0, 0);

    // 1: nop stream from reset
    rst_n = 1'b1;
    f_icode = 4'h1; f_valP = 64'h1;
    #1;
    chk_eq("t1.f_pc0", f_pc, 64'h0);
    step();
    chk_eq("t1.f_pc1", f_pc, 64'h1);
    chk_eq("t1.f_stat", f_stat, 64'd1);
    chk_ctl("t1", 0, 0, 0, 0);

    // 2: jXX predicted taken, later mispredicted
    f_icode = 4'h7; f_valC = 64'h40; f_valP = 64'hA;
    step();
    chk_eq("t2.pred_taken", f_pc, 64'h40);
    f_icode = 4'h1; f_valP = 64'h41;
    step();
    chk_eq("t2.seq", f_pc, 64'h41);
    f_valP = 64'hB;
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'hA;
    #1;
    chk_eq("t2.mp_pc", f_pc, 64'hA);
    chk_ctl("t2.mp", 0, 0, 1, 1);
    step();
    idle_inputs(); f_valP = 64'h20;
    #1;
    chk_eq("t2.after_mp", f_pc, 64'hB);
    chk_ctl("t2.after", 0, 0, 0, 0);

    // 3: ret at 0x20, three stall cycles, resolve to 0x13
    step();
    chk_eq("t3.pc20", f_pc, 64'h20);
    f_icode = 4'h9; f_valP = 64'h21;
    #1;
    chk_ctl("t3.fetch_ret", 0, 0, 0, 0);
    step();
    f_icode = 4'h1; f_valP = 64'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl($sformatf("t3.ret%0d", i), 1, 0, 1, 0);
      chk_eq($sformatf("t3.hold%0d", i), f_pc, 64'h21);
      step();
    end
    W_icode = 4'h9; W_valM = 64'h13; f_valP = 64'h14;
    #1;
    chk_eq("t3.ret_pc", f_pc, 64'h13);
    chk_ctl("t3.resolve", 0, 0, 0, 0);
    step();
    W_icode = 4'h1;
    #1;
    chk_eq("t3.after", f_pc, 64'h14);
    chk_ctl("t3.run", 0, 0, 0, 0);

    // 4: load/use hazard during RET
    f_icode = 4'h9; f_valP = 64'h15;
    step();
    f_icode = 4'h1;
    lu_hazard = 1'b1;
    #1;
    chk_ctl("t4.lu", 1, 1, 0, 1);
    step();
    lu_hazard = 1'b0;
    #1;
    chk_ctl("t4.still_ret", 1, 0, 1, 0);
    step();
    W_icode = 4'h9; W_valM = 64'h30; f_valP = 64'h31;
    #1;
    chk_eq("t4.ret_pc", f_pc, 64'h30);
    chk_ctl("t4.resolve", 0, 0, 0, 0);
    step();
    W_icode = 4'h1;
    #1;
    chk_eq("t4.after", f_pc, 64'h31);

    // 5: halt fetch, status classes, sticky cpu_halted
    f_icode = 4'h0;
    #1;
    chk_eq("t5.hlt_stat", f_stat, 64'd2);
    step();
    f_icode = 4'h1;
    #1;
    chk_ctl("t5.halt", 1, 0, 1, 0);
    chk_eq("t5.halt_hold", f_pc, 64'h31);
    f_icode = 4'hC;
    #1;
    chk_eq("t5.ins_stat", f_stat, 64'd4);
    f_icode = 4'h1; imem_error = 1'b1;
    #1;
    chk_eq("t5.imem_err", f_stat, 64'd3);
    imem_error = 1'b0;
    W_stat = 3'd2;
    step();
    W_stat = 3'd1;
    #1;
    chk_eq("t5.halted", cpu_halted, 64'd1);
    chk_ctl("t5.halted", 1, 0, 1, 1);
    step();
    chk_eq("t5.sticky", cpu_halted, 64'd1);
    chk_eq("t5.frozen_pc", f_pc, 64'h31);
    do_reset();
    chk_eq("t5.rst_clears", cpu_halted, 64'd0);

    // 5b: address-range boundary (IMEM_SIZE=2048)
    f_valP = 64'h7F6;
    step();
    chk_eq("t5.pc7F6_stat", f_stat, 64'd1);
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h7F7;
    #1;
    chk_eq("t5.pc7F7_stat", f_stat, 64'd3);
    M_valA = 64'h7FA;
    #1;
    chk_eq("t5.pc7FA_stat", f_stat, 64'd3);
    M_icode = 4'h1; M_Cnd = 1'b1;
    do_reset();

    // 6: halt on wrong path squashed by mispredict
    f_icode = 4'h7; f_valC = 64'h80;
    step();
    chk_eq("t6.pc80", f_pc, 64'h80);
    f_icode = 4'h0;
    step();
    f_icode = 4'h1;
    #1;
    chk_ctl("t6.halt", 1, 0, 1, 0);
    M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h5; f_valP = 64'h6;
    #1;
    chk_eq("t6.mp_pc", f_pc, 64'h5);
    chk_ctl("t6.mp", 0, 0, 1, 1);
    step();
    M_icode = 4'h1; M_Cnd = 1'b1;
    #1;
    chk_eq("t6.resume", f_pc, 64'h6);
    chk_ctl("t6.run", 0, 0, 0, 0);
    chk_eq("t6.not_halted", cpu_halted, 64'd0);

    // 6b: async reset in the middle of RET
    f_icode = 4'h9; f_valP = 64'h7;
    step();
    f_icode = 4'h1;
    #1;
    chk_ctl("t6.in_ret", 1, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("t6.async_pc", f_pc, 64'h0);
    chk_ctl("t6.async", 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    f_valP = 64'h1;
    step();
    chk_eq("t6.post_rst", f_pc, 64'h1);
    chk_ctl("t6.post_rst", 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
